fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end; replaces the fixed two-stage fetch pair of the pipelined CPU.
- Issues sequential PC reads to an instruction memory port with configurable read latency.
- Tracks in-flight reads, buffers returned words in a DEPTH-entry queue and presents {instr, pc} to decode over a valid/ready handshake.
- Supports flush/redirect from execute, and a halt.

---
 rtl/fetch_queue.sv | 183 ++++++++++++++++++
 tb/tb_fetch_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: parametrised instruction-fetch front end.
//   Issues sequential PC reads to a fixed-latency instruction memory, tracks
//   in-flight reads in a MEM_LAT-deep shift register, buffers returned words
//   in a DEPTH-entry queue and presents {instr, pc} over valid/ready.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   halt                block issue and hide the queue head (in-flight reads still land)
//   flush, redirect_tgt kill queue and in-flight reads, reload PC
//   mem_read_en/addr    read request to instruction memory
//   mem_read_data       read data, valid MEM_LAT cycles after the request
//   out_valid/ready     decode handshake
//   out_instr, out_pc   queue head payload
//   perf_issued/killed  performance counters
//
// Optional build macro: FETCH_QUEUE_PERF_EN enables the performance counters;
// without it both perf ports are tied to zero.
module fetch_queue #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       MEM_LAT  = 2,
   parameter int unsigned       DEPTH    = 4,
   parameter int unsigned       PC_STEP  = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt,
   input  logic              flush,
   input  logic [ADDR_W-1:0] redirect_tgt,
   output logic              mem_read_en,
   output logic [ADDR_W-1:0] mem_read_addr,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic [31:0]       perf_issued,
   output logic [31:0]       perf_killed
);

   localparam int unsigned PTR_W     = $clog2(DEPTH);
   localparam int unsigned CNT_W     = PTR_W + 1;
   localparam int unsigned LAT_CNT_W = $clog2(MEM_LAT + 1);
   localparam int unsigned CRED_W    = CNT_W + LAT_CNT_W;

   // Control registers
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [MEM_LAT-1:0] vld_sr_q, vld_sr_d;

   // Datapath storage (no reset needed; validity is tracked by control state)
   logic [ADDR_W-1:0]  pc_sr_q     [MEM_LAT];
   logic [DATA_W-1:0]  instr_mem_q [DEPTH];
   logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

   logic [LAT_CNT_W-1:0] inflight_c;
   logic [CRED_W-1:0]    credits_c;
   logic                 issue_c;
   logic                 ret_vld_c;
   logic                 push_c;
   logic                 pop_c;
   logic                 head_vld_c;

   // Credit check: queued entries plus reads still in the memory pipe
   always_comb begin
      inflight_c = '0;
      for (int unsigned i = 0; i < MEM_LAT; i++) begin
         inflight_c = inflight_c + LAT_CNT_W'(vld_sr_q[i]);
      end
      credits_c = CRED_W'(count_q) + CRED_W'(inflight_c);
      issue_c   = !rst && !flush && !halt && (credits_c < CRED_W'(DEPTH));
   end

   // The oldest shift-register stage lines up with the cycle its data returns
   assign ret_vld_c  = vld_sr_q[MEM_LAT-1];
   assign head_vld_c = (count_q != '0);
   assign push_c     = ret_vld_c && !flush && !rst;
   assign pop_c      = out_valid && out_ready && !flush;

   assign mem_read_en   = issue_c;
   assign mem_read_addr = pc_q;
   assign out_valid     = head_vld_c && !halt && !rst;
   assign out_instr     = head_vld_c ? instr_mem_q[rd_ptr_q] : '0;
   assign out_pc        = head_vld_c ? pc_mem_q[rd_ptr_q]    : '0;

   // Next-state logic
   always_comb begin
      pc_d     = pc_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      vld_sr_d = '0;

      if (flush) begin
         pc_d     = redirect_tgt;
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (issue_c) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
         end
         vld_sr_d[0] = issue_c;
         for (int unsigned i = 1; i < MEM_LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
         end
         if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      end
   end

   // Control state register
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         vld_sr_q <= '0;
      end else begin
         pc_q     <= pc_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         vld_sr_q <= vld_sr_d;
      end
   end

   // PC tracking pipe, parallel to the valid bits
   always_ff @(posedge clk) begin
      pc_sr_q[0] <= pc_q;
      for (int unsigned i = 1; i < MEM_LAT; i++) begin
         pc_sr_q[i] <= pc_sr_q[i-1];
      end
   end

   // Queue storage write
   always_ff @(posedge clk) begin
      if (push_c) begin
         instr_mem_q[wr_ptr_q] <= mem_read_data;
         pc_mem_q[wr_ptr_q]    <= pc_sr_q[MEM_LAT-1];
      end
   end

   // Issue credits must make a return into a full queue impossible
   overflow_chk: assert property (@(posedge clk) disable iff (rst)
      push_c |-> (count_q != CNT_W'(DEPTH)));

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] perf_issued_q;
   logic [31:0] perf_killed_q;

   // Issue count and number of reads discarded by flush
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issued_q <= '0;
         perf_killed_q <= '0;
      end else begin
         if (issue_c) begin
            perf_issued_q <= perf_issued_q + 32'd1;
         end
         if (flush) begin
            perf_killed_q <= perf_killed_q + 32'(credits_c);
         end
      end
   end

   assign perf_issued = perf_issued_q;
   assign perf_killed = perf_killed_q;
`else
   assign perf_issued = '0;
   assign perf_killed = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue.
//   DUT A: default parameters (MEM_LAT=2, DEPTH=4) driven through straight-line,
//          flush-with-reads-in-flight, backpressure and halt phases.
//   DUT B: DEPTH=2, MEM_LAT=3, RESET_PC=FFFFFFF8 for PC wrap and issue throttling.
//   Memory models return addr ^ A5A5A5A5 after the configured latency.
//   Expected pops are preloaded into per-DUT scoreboards; monitors compare on
//   every accepted handshake.
module tb_fetch_queue;

   localparam logic [31:0] XOR_K = 32'hA5A5_A5A5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        a_halt, a_flush, a_ready;
   logic [31:0] a_tgt;
   logic        a_en, a_valid;
   logic [31:0] a_addr, a_rdata, a_instr, a_pc, a_perf_iss, a_perf_kill;

   logic        b_en, b_valid;
   logic [31:0] b_addr, b_rdata, b_instr, b_pc, b_perf_iss, b_perf_kill;

   int tests = 0;
   int fails = 0;
   int pops_a = 0;
   int pops_b = 0;
   int b_issues = 0;

   logic [31:0] sb_a [$];
   logic [31:0] sb_b [$];

   fetch_queue u_dut_a (
      .clk(clk), .rst(rst), .halt(a_halt), .flush(a_flush), .redirect_tgt(a_tgt),
      .mem_read_en(a_en), .mem_read_addr(a_addr), .mem_read_data(a_rdata),
      .out_valid(a_valid), .out_ready(a_ready), .out_instr(a_instr), .out_pc(a_pc),
      .perf_issued(a_perf_iss), .perf_killed(a_perf_kill)
   );

   fetch_queue #(.DEPTH(2), .MEM_LAT(3), .RESET_PC(32'hFFFF_FFF8)) u_dut_b (
      .clk(clk), .rst(rst), .halt(1'b0), .flush(1'b0), .redirect_tgt(32'h0),
      .mem_read_en(b_en), .mem_read_addr(b_addr), .mem_read_data(b_rdata),
      .out_valid(b_valid), .out_ready(1'b1), .out_instr(b_instr), .out_pc(b_pc),
      .perf_issued(b_perf_iss), .perf_killed(b_perf_kill)
   );

   // Fixed-latency memory models
   logic [31:0] pipe_a [2];
   logic [31:0] pipe_b [3];
   always @(posedge clk) begin
      pipe_a[0] <= a_addr;
      pipe_a[1] <= pipe_a[0];
      pipe_b[0] <= b_addr;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign a_rdata = pipe_a[1] ^ XOR_K;
   assign b_rdata = pipe_b[2] ^ XOR_K;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor A: a handshake in a flush cycle is not a pop
   always @(negedge clk) begin
      if (!rst && a_valid && a_ready && !a_flush) begin
         pops_a++;
         if (sb_a.size() == 0) begin
            chk("a_unexpected_pop", a_pc, 32'hxxxx_xxxx);
         end else begin
            logic [31:0] e;
            e = sb_a.pop_front();
            chk("a_pop_pc", a_pc, e);
            chk("a_pop_instr", a_instr, e ^ XOR_K);
         end
      end
   end

   // Monitor B: out_ready tied high
   always @(negedge clk) begin
      if (!rst && b_valid) begin
         pops_b++;
         if (sb_b.size() == 0) begin
            chk("b_unexpected_pop", b_pc, 32'hxxxx_xxxx);
         end else begin
            logic [31:0] e;
            e = sb_b.pop_front();
            chk("b_pop_pc", b_pc, e);
            chk("b_pop_instr", b_instr, e ^ XOR_K);
         end
      end
   end

   initial begin
      rst     = 1'b1;
      a_halt  = 1'b0;
      a_flush = 1'b0;
      a_ready = 1'b1;
      a_tgt   = 32'h0;

      // A: 0,4,8 pop before the flush in cycle 6 kills 0xC (queued) and 0x10,0x14 (in flight)
      sb_a.push_back(32'h0);
      sb_a.push_back(32'h4);
      sb_a.push_back(32'h8);
      for (int i = 0; i < 60; i++) sb_a.push_back(32'h100 + 32'(4 * i));
      for (int i = 0; i < 40; i++) sb_b.push_back(32'hFFFF_FFF8 + 32'(4 * i));

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_a_en", 32'(a_en), 32'd0);
      chk("rst_a_valid", 32'(a_valid), 32'd0);
      chk("rst_a_pc", a_pc, 32'h0);
      chk("rst_a_instr", a_instr, 32'h0);
      chk("rst_b_en", 32'(b_en), 32'd0);
      chk("rst_b_valid", 32'(b_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int c = 0; c < 46; c++) begin
         case (c)
            6:  begin a_flush = 1'b1; a_tgt = 32'h100; a_ready = 1'b0; end
            7:  a_flush = 1'b0;
            16: a_ready = 1'b1;
            27: a_halt = 1'b1;
            32: a_halt = 1'b0;
            default: ;
         endcase
         @(negedge clk);
         if (c < 20 && b_en) b_issues++;
         if (c == 0) begin
            chk("first_issue_en", 32'(a_en), 32'd1);
            chk("first_issue_addr", a_addr, 32'h0);
         end
         if (c == 2) chk("valid_before_latency", 32'(a_valid), 32'd0);
         if (c == 3) begin
            chk("first_valid", 32'(a_valid), 32'd1);
            chk("first_pc", a_pc, 32'h0);
         end
         if (c == 6) begin
            chk("flush_no_issue", 32'(a_en), 32'd0);
`ifdef FETCH_QUEUE_PERF_EN
            chk("perf_issued", a_perf_iss, 32'd6);
`else
            chk("perf_issued_tied", a_perf_iss, 32'd0);
`endif
         end
         if (c == 7) begin
            chk("post_flush_valid", 32'(a_valid), 32'd0);
            chk("redirect_en", 32'(a_en), 32'd1);
            chk("redirect_addr", a_addr, 32'h100);
`ifdef FETCH_QUEUE_PERF_EN
            chk("perf_killed", a_perf_kill, 32'd3);
`else
            chk("perf_killed_tied", a_perf_kill, 32'd0);
`endif
         end
         if (c >= 11 && c <= 15) chk("bp_no_issue", 32'(a_en), 32'd0);
         if (c >= 13 && c <= 15) begin
            chk("bp_valid", 32'(a_valid), 32'd1);
            chk("bp_head_pc", a_pc, 32'h100);
            chk("bp_head_instr", a_instr, 32'h100 ^ XOR_K);
         end
         if (c >= 27 && c <= 31) begin
            chk("halt_valid", 32'(a_valid), 32'd0);
            chk("halt_no_issue", 32'(a_en), 32'd0);
         end
         @(posedge clk); #1;
      end

      chk("b_issue_rate", 32'(b_issues), 32'd8);
      chk("a_pops_min", 32'(pops_a >= 24), 32'd1);
      chk("b_pops_min", 32'(pops_b >= 14), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
